// File: rtl/mux_behaviour.sv
// rtl/mux_behaviour.sv - N-to-1 flag selector with registered copy and saturating toggle counter (option macro: MUX_BEHAVIOUR_ONEHOT_EN)

module mux_behaviour #(
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  i,
    input  logic [SEL_W-1:0] s,
    output logic             y,
    output logic             y_q,
    output logic             s_err,
    output logic [CNT_W-1:0] tog_cnt
`ifdef MUX_BEHAVIOUR_ONEHOT_EN
    ,
    output logic [N_IN-1:0]  sel_oh
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_IN-1:0]  w_oh;
    logic             w_y;
    logic             w_s_err;

    logic             r_y_q;
    logic             r_s_err;
    logic [CNT_W-1:0] r_tog_cnt;

    // Lane decode: s matches at most one legal lane; an out-of-range s matches none, forcing y to 0
    always_comb begin
        w_oh = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_oh[k] = (s == SEL_W'(k));
        end
    end

    assign w_y     = |(i & w_oh);
    assign w_s_err = ({1'b0, s} >= (SEL_W + 1)'(N_IN));
    assign y       = w_y;

    // Time-aligned copy of the selected flag and the out-of-range indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q   <= 1'b0;
            r_s_err <= 1'b0;
        end else begin
            r_y_q   <= w_y;
            r_s_err <= w_s_err;
        end
    end

    // Activity monitor: count changes of y_q, holding at full scale until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tog_cnt <= '0;
        end else if ((w_y != r_y_q) && (r_tog_cnt != CNT_MAX)) begin
            r_tog_cnt <= r_tog_cnt + 1'b1;
        end
    end

    assign y_q     = r_y_q;
    assign s_err   = r_s_err;
    assign tog_cnt = r_tog_cnt;

`ifdef MUX_BEHAVIOUR_ONEHOT_EN
    logic [N_IN-1:0] r_sel_oh;

    // Registered one-hot view of the select, updated on the same edge as y_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_oh <= '0;
        end else begin
            r_sel_oh <= w_oh;
        end
    end

    assign sel_oh = r_sel_oh;
`endif

endmodule

// File: tb/tb_mux_behaviour.sv
// tb/tb_mux_behaviour.sv - self-checking bench for mux_behaviour (N_IN=4 and N_IN=3 instances)

module tb_mux_behaviour;

    logic       clk;
    logic       rst_n;
    logic [3:0] i4;
    logic [1:0] s4;
    logic       y4, y_q4, s_err4;
    logic [7:0] tog4;
    logic [2:0] i3;
    logic [1:0] s3;
    logic       y3, y_q3, s_err3;
    logic [7:0] tog3;
`ifdef MUX_BEHAVIOUR_ONEHOT_EN
    logic [3:0] sel_oh4;
    logic [2:0] sel_oh3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_yq4, m_serr4, m_cnt4, m_oh4;
    int m_yq3, m_serr3, m_cnt3, m_oh3;

    mux_behaviour #(.N_IN(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i(i4), .s(s4),
        .y(y4), .y_q(y_q4), .s_err(s_err4), .tog_cnt(tog4)
`ifdef MUX_BEHAVIOUR_ONEHOT_EN
        , .sel_oh(sel_oh4)
`endif
    );

    mux_behaviour #(.N_IN(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i(i3), .s(s3),
        .y(y3), .y_q(y_q3), .s_err(s_err3), .tog_cnt(tog3)
`ifdef MUX_BEHAVIOUR_ONEHOT_EN
        , .sel_oh(sel_oh3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] iv;
        logic [1:0] sv;
        logic       ey;
    } comb_vec_t;

    typedef struct {
        logic [1:0] sv;
        logic       eyq;
        logic [7:0] ecnt;
    } seq_vec_t;

    comb_vec_t cv[4];
    seq_vec_t  sq[4];

    function automatic int ref_y(input int iv, input int sv, input int n);
        if (sv >= n) return 0;
        return (iv >> sv) & 1;
    endfunction

    function automatic int ref_oh(input int sv, input int n);
        if (sv >= n) return 0;
        return 1 << sv;
    endfunction

    function automatic int sat(input int c);
        return (c > 255) ? 255 : c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_yq4 = 0; m_serr4 = 0; m_cnt4 = 0; m_oh4 = 0;
        m_yq3 = 0; m_serr3 = 0; m_cnt3 = 0; m_oh3 = 0;
    endtask

    // One clock edge; the model advances from the inputs present before the edge
    task automatic step();
        int ny4, ny3, ne4, ne3, no4, no3;
        ny4 = ref_y(int'(i4), int'(s4), 4);
        ny3 = ref_y(int'(i3), int'(s3), 3);
        ne4 = (int'(s4) >= 4) ? 1 : 0;
        ne3 = (int'(s3) >= 3) ? 1 : 0;
        no4 = ref_oh(int'(s4), 4);
        no3 = ref_oh(int'(s3), 3);
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (ny4 != m_yq4) m_cnt4++;
            if (ny3 != m_yq3) m_cnt3++;
            m_yq4 = ny4; m_serr4 = ne4; m_oh4 = no4;
            m_yq3 = ny3; m_serr3 = ne3; m_oh3 = no3;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y_q4"},   int'(y_q4),   m_yq4);
        chk({tag, ".s_err4"}, int'(s_err4), m_serr4);
        chk({tag, ".tog4"},   int'(tog4),   sat(m_cnt4));
        chk({tag, ".y_q3"},   int'(y_q3),   m_yq3);
        chk({tag, ".s_err3"}, int'(s_err3), m_serr3);
        chk({tag, ".tog3"},   int'(tog3),   sat(m_cnt3));
`ifdef MUX_BEHAVIOUR_ONEHOT_EN
        chk({tag, ".sel_oh4"}, int'(sel_oh4), m_oh4);
        chk({tag, ".sel_oh3"}, int'(sel_oh3), m_oh3);
`endif
    endtask

    initial begin
        cv[0] = '{iv: 4'd5,  sv: 2'd2, ey: 1'b1};
        cv[1] = '{iv: 4'd15, sv: 2'd3, ey: 1'b1};
        cv[2] = '{iv: 4'd6,  sv: 2'd1, ey: 1'b1};
        cv[3] = '{iv: 4'd6,  sv: 2'd0, ey: 1'b0};

        sq[0] = '{sv: 2'd0, eyq: 1'b0, ecnt: 8'd0};
        sq[1] = '{sv: 2'd1, eyq: 1'b1, ecnt: 8'd1};
        sq[2] = '{sv: 2'd0, eyq: 1'b0, ecnt: 8'd2};
        sq[3] = '{sv: 2'd1, eyq: 1'b1, ecnt: 8'd3};

        // Reset state
        rst_n = 1'b1; i4 = '0; s4 = '0; i3 = '0; s3 = '0;
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset.y",     int'(y4),     0);
        chk("reset.y_q",   int'(y_q4),   0);
        chk("reset.tog",   int'(tog4),   0);
        chk("reset.s_err", int'(s_err4), 0);
`ifdef MUX_BEHAVIOUR_ONEHOT_EN
        chk("reset.sel_oh", int'(sel_oh4), 0);
`endif

        // Combinational path, registers held in reset
        for (int k = 0; k < 4; k++) begin
            i4 = cv[k].iv;
            s4 = cv[k].sv;
            #1;
            chk($sformatf("comb[%0d].y", k), int'(y4), int'(cv[k].ey));
        end
        chk("comb.y_q_held", int'(y_q4), 0);

        // Registered path after release
        @(negedge clk);
        rst_n = 1'b1;
        i4 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            s4 = sq[k].sv;
            step();
            chk($sformatf("seq[%0d].y_q", k), int'(y_q4), int'(sq[k].eyq));
            chk($sformatf("seq[%0d].tog", k), int'(tog4), int'(sq[k].ecnt));
        end
        check_all("seq");

        // Randomized traffic on both instances
        for (int n = 0; n < 200; n++) begin
            i4 = 4'($urandom);
            s4 = 2'($urandom_range(0, 3));
            i3 = 3'($urandom);
            s3 = 2'($urandom_range(0, 3));
            #1;
            chk("rand.y4", int'(y4), ref_y(int'(i4), int'(s4), 4));
            chk("rand.y3", int'(y3), ref_y(int'(i3), int'(s3), 3));
            step();
            check_all("rand");
        end

        // Out-of-range select on the 3-lane instance
        i3 = 3'b111;
        s3 = 2'd3;
        #1;
        chk("n3.y_oor", int'(y3), 0);
        step();
        chk("n3.s_err_set", int'(s_err3), 1);
        chk("n3.y_q_oor",   int'(y_q3),   0);
`ifdef MUX_BEHAVIOUR_ONEHOT_EN
        chk("n3.sel_oh_oor", int'(sel_oh3), 0);
`endif
        s3 = 2'd2;
        step();
        chk("n3.s_err_clr", int'(s_err3), 0);
        chk("n3.y_q_lane2", int'(y_q3),   1);
`ifdef MUX_BEHAVIOUR_ONEHOT_EN
        chk("n3.sel_oh_lane2", int'(sel_oh3), 4);
`endif
        check_all("n3");

        // Saturation: y toggles on every edge for 300 cycles
        i4 = 4'b1010;
        s3 = 2'd3;
        for (int c = 0; c < 300; c++) begin
            s4 = (int'(y_q4) == 1) ? 2'd0 : 2'd1;
            step();
        end
        chk("sat.tog", int'(tog4), 255);
        check_all("sat");

        // Mid-operation reset while saturated, between edges
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst1.tog",    int'(tog4),   0);
        chk("midrst1.s_err3", int'(s_err3), 0);
        check_all("midrst1");

        // Build tog_cnt=11 with y_q=1, then reset between edges
        @(negedge clk);
        rst_n = 1'b1;
        i4 = 4'b0001;
        for (int k = 0; k < 11; k++) begin
            s4 = 2'(k % 2);
            step();
        end
        chk("pre_rst.tog", int'(tog4),   11);
        chk("pre_rst.y_q", int'(y_q4),   1);
        chk("pre_rst.s_err3", int'(s_err3), 1);
        check_all("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst2.y_q",    int'(y_q4),   0);
        chk("midrst2.tog",    int'(tog4),   0);
        chk("midrst2.s_err3", int'(s_err3), 0);
        check_all("midrst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
